// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage next-PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    HALT = 2'd3
  } pc_seq_state_e;

  // Width of a word-index PC able to address max_num_instruc words.
  function automatic int pc_w(input int max_num_instruc);
    return (max_num_instruc > 1) ? $clog2(max_num_instruc) : 1;
  endfunction

endpackage

// File: rtl/pc_seq_perf.sv
// Saturating performance counters for pc_sequencer (stall cycles, redirects, halt entries).
module pc_seq_perf (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        stall_evt_i,
  input  logic        redirect_evt_i,
  input  logic        halt_evt_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] redirect_cnt_o,
  output logic [15:0] halt_cnt_o
);

  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic [15:0] halt_cnt_q, halt_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    halt_cnt_d     = halt_cnt_q;
    if (clear_i) begin
      stall_cnt_d    = '0;
      redirect_cnt_d = '0;
      halt_cnt_d     = '0;
    end else begin
      // Each counter sticks at all-ones instead of wrapping.
      if (stall_evt_i && (stall_cnt_q != '1))       stall_cnt_d    = stall_cnt_q + 32'd1;
      if (redirect_evt_i && (redirect_cnt_q != '1)) redirect_cnt_d = redirect_cnt_q + 32'd1;
      if (halt_evt_i && (halt_cnt_q != '1))         halt_cnt_d     = halt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      halt_cnt_q     <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      halt_cnt_q     <= halt_cnt_d;
    end
  end

  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign halt_cnt_o     = halt_cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage: advance, redirect, stall/halt hold, pending redirect.
// Optional counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter  int MaxNumInstruc = 100,
  localparam int PcW           = pc_w(MaxNumInstruc)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic [PcW-1:0] pc_cur_i,
  input  logic           stall_i,
  input  logic           mem_wait_i,
  input  logic           redirect_i,
  input  logic [PcW-1:0] redirect_target_i,
  input  logic           halt_i,
  input  logic           restart_i,
  output logic [PcW-1:0] pc_next_o,
  output logic           fetch_valid_o,
  output logic           flush_o,
  output logic           halted_o,
  output logic           range_err_o
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]    stall_cnt_o,
  output logic [31:0]    redirect_cnt_o,
  output logic [15:0]    halt_cnt_o
`endif
);

  localparam logic [PcW-1:0] LastPc  = PcW'(MaxNumInstruc - 1);
  localparam logic [PcW:0]   DepthCmp = (PcW + 1)'(MaxNumInstruc);

  pc_seq_state_e  state_q, state_d;
  logic [PcW-1:0] pend_q, pend_d;
  logic           range_err_q, range_err_d;
  logic           tgt_oob;

  // One extra bit so a depth of exactly 2**PcW still compares correctly.
  assign tgt_oob = ({1'b0, redirect_target_i} >= DepthCmp);

  // While reset is held the state sits in BOOT, whose outputs are already all zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d       = state_q;
    pend_d        = pend_q;
    range_err_d   = range_err_q;
    pc_next_o     = pc_cur_i;
    fetch_valid_o = 1'b0;
    flush_o       = 1'b0;

    unique case (state_q)
      BOOT: begin
        pc_next_o = '0;
        state_d   = RUN;
      end

      RUN: begin
        fetch_valid_o = !(halt_i || redirect_i || mem_wait_i);
        if (halt_i) begin
          flush_o = 1'b1;
          state_d = HALT;
        end else if (redirect_i && tgt_oob) begin
          flush_o     = 1'b1;
          range_err_d = 1'b1;
          state_d     = HALT;
        end else if (redirect_i && mem_wait_i) begin
          flush_o = 1'b1;
          pend_d  = redirect_target_i;
          state_d = WAIT;
        end else if (redirect_i) begin
          // The branch is older than any stalled instruction, so it wins over stall_i.
          flush_o   = 1'b1;
          pc_next_o = redirect_target_i;
        end else if (!(stall_i || mem_wait_i)) begin
          if (pc_cur_i == LastPc) state_d = HALT;
          else                    pc_next_o = pc_cur_i + PcW'(1);
        end
      end

      WAIT: begin
        if (halt_i) begin
          pend_d  = '0;
          state_d = HALT;
        end else if (redirect_i && tgt_oob) begin
          range_err_d = 1'b1;
          state_d     = HALT;
        end else begin
          if (redirect_i) pend_d = redirect_target_i;
          if (!mem_wait_i) begin
            pc_next_o = pend_d;
            state_d   = RUN;
          end
        end
      end

      HALT: begin
        if (restart_i) begin
          pc_next_o   = '0;
          flush_o     = 1'b1;
          range_err_d = 1'b0;
          state_d     = RUN;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= BOOT;
      pend_q      <= '0;
      range_err_q <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignment so all flops sample the same pre-edge values.
      state_q     <= state_d;
      pend_q      <= pend_d;
      range_err_q <= range_err_d;
    end
  end

  assign halted_o    = (state_q == HALT);
  assign range_err_o = range_err_q;

`ifdef PC_SEQ_PERF_EN
  logic active, stall_evt, redirect_evt, halt_evt;

  assign active       = (state_q == RUN) || (state_q == WAIT);
  assign stall_evt    = active && !fetch_valid_o;
  assign redirect_evt = active && redirect_i && !halt_i && !tgt_oob;
  assign halt_evt     = (state_d == HALT) && (state_q != HALT);

  pc_seq_perf u_perf (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .clear_i        (restart_i),
    .stall_evt_i    (stall_evt),
    .redirect_evt_i (redirect_evt),
    .halt_evt_i     (halt_evt),
    .stall_cnt_o    (stall_cnt_o),
    .redirect_cnt_o (redirect_cnt_o),
    .halt_cnt_o     (halt_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with a behavioural PC register closing the loop.
module tb_pc_sequencer;

  localparam int PcW = 7;

  typedef struct {
    int cur;
    int stall, mem_wait, redirect, target, halt, restart;
    int nxt, fv, fl, hl, re;
  } vec_t;

  logic           clk;
  logic           reset_n;
  logic [PcW-1:0] pc_cur;
  logic           stall, mem_wait, redirect, halt, restart;
  logic [PcW-1:0] target;
  logic [PcW-1:0] pc_next;
  logic           fetch_valid, flush, halted, range_err;
`ifdef PC_SEQ_PERF_EN
  logic [31:0]    stall_cnt, redirect_cnt;
  logic [15:0]    halt_cnt;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  pc_sequencer #(.MaxNumInstruc(100)) dut (
    .clk_i             (clk),
    .reset_i           (reset_n),
    .pc_cur_i          (pc_cur),
    .stall_i           (stall),
    .mem_wait_i        (mem_wait),
    .redirect_i        (redirect),
    .redirect_target_i (target),
    .halt_i            (halt),
    .restart_i         (restart),
    .pc_next_o         (pc_next),
    .fetch_valid_o     (fetch_valid),
    .flush_o           (flush),
    .halted_o          (halted),
    .range_err_o       (range_err)
`ifdef PC_SEQ_PERF_EN
    ,
    .stall_cnt_o       (stall_cnt),
    .redirect_cnt_o    (redirect_cnt),
    .halt_cnt_o        (halt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The PC register the sequencer feeds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_cur <= '0;
    else          pc_cur <= pc_next;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int cur, input int st, input int mw, input int rd, input int tg,
                     input int hl_in, input int rs, input int nxt, input int fv, input int fl,
                     input int hl, input int re);
    vec_t v;
    v.cur = cur; v.stall = st; v.mem_wait = mw; v.redirect = rd; v.target = tg;
    v.halt = hl_in; v.restart = rs; v.nxt = nxt; v.fv = fv; v.fl = fl; v.hl = hl; v.re = re;
    vecs.push_back(v);
  endtask

  task automatic drive(input int st, input int mw, input int rd, input int tg,
                       input int hl_in, input int rs);
    stall    = st[0];
    mem_wait = mw[0];
    redirect = rd[0];
    target   = tg[PcW-1:0];
    halt     = hl_in[0];
    restart  = rs[0];
  endtask

  task automatic check_outs(input string tag, input int cur, input int nxt, input int fv,
                            input int fl, input int hl, input int re);
    check({tag, " pc_cur"},      32'(pc_cur),      32'(cur));
    check({tag, " pc_next"},     32'(pc_next),     32'(nxt));
    check({tag, " fetch_valid"}, 32'(fetch_valid), 32'(fv));
    check({tag, " flush"},       32'(flush),       32'(fl));
    check({tag, " halted"},      32'(halted),      32'(hl));
    check({tag, " range_err"},   32'(range_err),   32'(re));
  endtask

  initial begin
    // cur  st mw rd tgt hl rs   nxt fv fl hl re
    add(0,   0, 0, 0, 0,  0, 0,   0,  0, 0, 0, 0);   // BOOT
    for (int i = 0; i < 10; i++) add(i, 0, 0, 0, 0, 0, 0, i + 1, 1, 0, 0, 0);
    add(10,  1, 0, 1, 40, 0, 0,   40, 0, 1, 0, 0);   // redirect beats stall
    add(40,  1, 0, 0, 0,  0, 0,   40, 1, 0, 0, 0);   // stall hold
    add(40,  0, 1, 0, 0,  0, 0,   40, 0, 0, 0, 0);   // mem_wait hold
    add(40,  0, 0, 0, 0,  0, 0,   41, 1, 0, 0, 0);
    add(41,  0, 0, 1, 20, 0, 0,   20, 0, 1, 0, 0);
    add(20,  0, 1, 1, 55, 0, 0,   20, 0, 1, 0, 0);   // buffered redirect -> WAIT
    add(20,  0, 1, 1, 60, 0, 0,   20, 0, 0, 0, 0);   // newest wins
    add(20,  0, 1, 0, 0,  0, 0,   20, 0, 0, 0, 0);
    add(20,  0, 0, 0, 0,  0, 0,   60, 0, 0, 0, 0);   // release pending
    add(60,  0, 0, 0, 0,  0, 0,   61, 1, 0, 0, 0);
    add(61,  0, 0, 1, 100,0, 0,   61, 0, 1, 0, 0);   // out of range
    add(61,  0, 0, 0, 0,  0, 0,   61, 0, 0, 1, 1);
    add(61,  1, 0, 1, 5,  0, 0,   61, 0, 0, 1, 1);   // ignored in HALT
    add(61,  0, 0, 0, 0,  0, 1,   0,  0, 1, 1, 1);   // restart
    add(0,   0, 0, 0, 0,  0, 0,   1,  1, 0, 0, 0);
    add(1,   0, 0, 1, 30, 1, 0,   1,  0, 1, 0, 0);   // halt beats redirect
    add(1,   0, 0, 0, 0,  0, 0,   1,  0, 0, 1, 0);
    add(1,   0, 0, 0, 0,  0, 1,   0,  0, 1, 1, 0);
    for (int i = 0; i < 99; i++) add(i, 0, 0, 0, 0, 0, 0, i + 1, 1, 0, 0, 0);
    add(99,  0, 0, 0, 0,  0, 0,   99, 1, 0, 0, 0);   // last word, no wrap
    add(99,  0, 0, 1, 5,  0, 0,   99, 0, 0, 1, 0);
    add(99,  1, 0, 0, 0,  0, 0,   99, 0, 0, 1, 0);
    add(99,  0, 0, 0, 0,  0, 1,   0,  0, 1, 1, 0);
    add(0,   0, 0, 0, 0,  0, 0,   1,  1, 0, 0, 0);
    add(1,   0, 1, 1, 10, 0, 0,   1,  0, 1, 0, 0);   // WAIT pending 10
    add(1,   0, 1, 0, 0,  1, 0,   1,  0, 0, 0, 0);   // halt discards pending
    add(1,   0, 0, 0, 0,  0, 0,   1,  0, 0, 1, 0);
    add(1,   0, 0, 0, 0,  0, 1,   0,  0, 1, 1, 0);
    add(0,   0, 1, 1, 50, 0, 0,   0,  0, 1, 0, 0);
    add(0,   0, 1, 1, 127,0, 0,   0,  0, 0, 0, 0);   // out of range from WAIT
    add(0,   0, 0, 0, 0,  0, 0,   0,  0, 0, 1, 1);
    add(0,   0, 0, 0, 0,  0, 1,   0,  0, 1, 1, 1);
    add(0,   0, 0, 0, 0,  0, 0,   1,  1, 0, 0, 0);
    add(1,   0, 0, 0, 0,  0, 0,   2,  1, 0, 0, 0);
    add(2,   0, 1, 1, 30, 0, 0,   2,  0, 1, 0, 0);   // WAIT pending 30
    add(2,   0, 1, 0, 0,  0, 0,   2,  0, 0, 0, 0);

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1 check_outs("reset", 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].mem_wait, vecs[i].redirect, vecs[i].target,
            vecs[i].halt, vecs[i].restart);
      #1 check_outs($sformatf("row%0d", i), vecs[i].cur, vecs[i].nxt, vecs[i].fv,
                    vecs[i].fl, vecs[i].hl, vecs[i].re);
      @(negedge clk);
    end

    // Reset mid-WAIT with a redirect still presented; pending 30 must not survive.
    drive(0, 1, 1, 30, 0, 0);
    reset_n = 1'b0;
    #1 check_outs("wait_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 check_outs("wait_rst_hold", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check_outs("post_rst_boot", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1 check_outs("post_rst_run0", 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    #1 check_outs("post_rst_run1", 1, 2, 1, 0, 0, 0);

    // Async reset clears a sticky range error without waiting for a clock edge.
    @(negedge clk);
    drive(0, 0, 1, 120, 0, 0);
    #1 check_outs("oob_again", 2, 2, 0, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    #1 check_outs("oob_halted", 2, 2, 0, 0, 1, 1);
    #2 reset_n = 1'b0;
    #1 check_outs("oob_async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 check_outs("oob_rst_run", 0, 1, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the fetch stage.
- Generates the word-index PC_i value for the PC register each cycle: sequential advance, redirect, stall-hold, or halt-hold.
- Reads back the registered PC output, buffers redirects that arrive while fetch is blocked, emits pipeline flush pulses, and detects end-of-program and out-of-range targets.
- Sits between the hazard unit, the EX-stage branch/jump resolution and the PC register.

Parameters:
MaxNumInstruc, 100, instruction memory depth in words; PcW = $clog2(MaxNumInstruc) is the PC width.

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  asynchronous, active-low reset
pc_cur_i  input  PcW  current PC (PC register output)
stall_i  input  1  hazard-unit stall (load-use); hold PC
mem_wait_i  input  1  instruction memory not ready; fetch blocked
redirect_i  input  1  taken branch/jump resolved in EX
redirect_target_i  input  PcW  redirect word index
halt_i  input  1  halting instruction (ecall/ebreak) committed
restart_i  input  1  leave HALT, restart at PC 0
pc_next_o  output  PcW  value for PC register input
fetch_valid_o  output  1  fetched instruction this cycle is valid
flush_o  output  1  squash IF/ID and ID/EX this cycle
halted_o  output  1  sequencer in HALT
range_err_o  output  1  sticky: out-of-range redirect seen

Behaviour:
- The FSM is registered and reset asynchronously. States: BOOT, RUN, WAIT, HALT.
- pc_next_o, fetch_valid_o and flush_o are combinational from state, registers and inputs. This gives a PC-register latency of 1: a redirect applied in cycle N appears on pc_cur_i in N+1.
- Reset (reset_i=0), at any time including mid-redirect:
  - state=BOOT; pending-redirect register cleared; range_err_o=0.
  - Outputs while in reset: pc_next_o=0, fetch_valid_o=0, flush_o=0, halted_o=0.
- BOOT: pc_next_o=0, fetch_valid_o=0. Unconditionally goes to RUN the next cycle.
- RUN, evaluated in priority order:
  1. halt_i: pc_next_o=pc_cur_i; go to HALT; flush_o=1.
  2. redirect_i with target >= MaxNumInstruc: set range_err_o; go to HALT; flush_o=1.
  3. redirect_i with mem_wait_i=1: latch the target into pending; go to WAIT; pc_next_o=pc_cur_i; flush_o=1.
  4. redirect_i: pc_next_o=target; flush_o=1. Redirect overrides stall_i, because the branch is older than the stalled instruction.
  5. stall_i or mem_wait_i: pc_next_o=pc_cur_i.
  6. pc_cur_i == MaxNumInstruc-1: pc_next_o=pc_cur_i; go to HALT. No wrap to 0.
  7. Otherwise: pc_next_o=pc_cur_i+1, with the addition done in PcW bits.
- fetch_valid_o=1 in RUN only when none of halt_i, redirect_i, mem_wait_i is set.
- WAIT: pc_next_o=pc_cur_i; fetch_valid_o=0; flush_o=0.
  - A new in-range redirect_i overwrites pending (newest wins).
  - An out-of-range redirect sets range_err_o and goes to HALT.
  - When mem_wait_i=0: pc_next_o=pending; go to RUN.
  - halt_i in WAIT goes to HALT and discards pending.
- HALT: pc_next_o=pc_cur_i; fetch_valid_o=0; halted_o=1. redirect_i and stall_i are ignored.
  - restart_i=1: pc_next_o=0; flush_o=1; range_err_o cleared; go to RUN.
- Simultaneous halt_i and redirect_i: halt wins.

Optional Feature:
PC_SEQ_PERF_EN
- Defined: adds outputs stall_cnt_o[31:0], redirect_cnt_o[31:0] and halt_cnt_o[15:0].
  - stall_cnt_o counts RUN/WAIT cycles with fetch_valid_o=0.
  - redirect_cnt_o counts accepted redirects.
  - halt_cnt_o counts HALT entries.
  - All counters saturate at all-ones, clear on reset and on restart_i.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pc_seq_pkg holds:
  - typedef enum logic [1:0] pc_seq_state_e {BOOT, RUN, WAIT, HALT};
  - a function pc_w(MaxNumInstruc) returning $clog2 width.
- Natural sub-module: pc_seq_perf, holding the saturating counters and instantiated only under PC_SEQ_PERF_EN.

Test Plan:
All scenarios use MaxNumInstruc=100 (PcW=7).
1. Release reset, no stimulus -> cycle 1 pc_next_o=0 with fetch_valid_o=0 (BOOT); then pc_cur_i walks 0,1,2,3…; fetch_valid_o=1 from RUN onward.
2. At pc_cur_i=10, redirect_i=1, target=40, stall_i=1 -> flush_o=1 that cycle; pc_cur_i=40 next cycle.
3. At pc_cur_i=20, redirect target=55 with mem_wait_i=1 held 3 cycles, second redirect target=60 in cycle 2 -> PC stays 20; pc_cur_i=60 the cycle after mem_wait_i drops.
4. Sequential run to pc_cur_i=99 -> halted_o=1; PC holds at 99; redirect to 5 is ignored; restart_i -> pc_cur_i=0, flush_o=1.
5. Redirect target=100 -> range_err_o=1 and halted_o=1; range_err_o stays set until restart_i.
6. Assert reset_i=0 mid-WAIT with pending=30 -> all outputs reset immediately; after release, PC starts at 0, not 30.
